// File: rtl/fm_dump_pkg.sv
// Shared definitions for the FM debug capture path: FSM states, CTRL bit map,
// FM hardware state codes and status word layout.
package fm_dump_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } cap_state_t;

  typedef enum logic [1:0] {
    RD_NONE,
    RD_STAT,
    RD_BUF,
    RD_ZERO
  } rd_kind_t;

  localparam int CTRL_ARM       = 0;
  localparam int CTRL_STOP      = 1;
  localparam int CTRL_ABORT     = 2;
  localparam int CTRL_ACK       = 3;
  localparam int CTRL_MODE      = 4;
  localparam int CTRL_CHSEL_LSB = 8;
  localparam int CTRL_CHSEL_W   = 4;

  localparam logic [3:0] HW_IDLE = 4'b0001;
  localparam logic [3:0] HW_RCEV = 4'b0010;
  localparam logic [3:0] HW_RSSI = 4'b0100;

  localparam int STAT_WRAPPED_BIT = 31;
  localparam int STAT_MODE_BIT    = 30;
  localparam int STAT_STATE_LSB   = 28;
  localparam int STAT_COUNT_W     = 14;

endpackage

// File: rtl/fm_capture_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// Read-before-write, so a same-entry read in the write cycle returns old data.
module fm_capture_ram #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/fm_capture_buffer.sv
// Multi-channel capture buffer for the FM receiver debug path: one-shot/ring
// capture FSM, done interrupt and register-bus readback of status and samples.
module fm_capture_buffer
  import fm_dump_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter int                NUM_CH     = 2,
  parameter int                DEPTH_LOG2 = 12,
  parameter int                BUS_AW     = 13,
  parameter logic [BUS_AW-1:0] CTRL_ADDR  = 'h004,
  parameter logic [BUS_AW-1:0] STAT_ADDR  = 'h008,
  parameter logic [BUS_AW-1:0] BASE_ADDR  = 'h100
) (
  input  logic                     clk,
  input  logic                     RSTn,
  input  logic [BUS_AW-1:0]        wraddr,
  input  logic [31:0]              wdata,
  input  logic [3:0]               wea,
  input  logic [BUS_AW-1:0]        rdaddr,
  output logic [31:0]              rdata,
  input  logic [3:0]               hw_state,
  input  logic                     smp_valid,
  input  logic [NUM_CH*DATA_W-1:0] smp_data,
  output logic                     busy,
  output logic                     irq_done
);

  localparam int SMP_W = NUM_CH * DATA_W;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_W'(DEPTH)) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [STAT_COUNT_W-1:0] fit_count(input logic [CNT_W-1:0] v);
    logic [31:0] w;
    w = 32'(v);
    return w[STAT_COUNT_W-1:0];
  endfunction

  function automatic logic [31:0] pack_status(input logic w, input logic m,
                                              input cap_state_t s,
                                              input logic [CNT_W-1:0] c);
    logic [31:0] word;
    word = '0;
    word[STAT_WRAPPED_BIT]              = w;
    word[STAT_MODE_BIT]                 = m;
    word[STAT_STATE_LSB +: 2]           = s;
    word[STAT_COUNT_W-1:0]              = fit_count(c);
    return word;
  endfunction

  cap_state_t            state;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [CNT_W-1:0]      count;
  logic                  wrapped;
  logic                  mode;
  logic [3:0]            ch_sel;

  logic ctrl_wr, arm, stop, abort, ack, rcev, smp_we, last_slot;
  logic unused_wdata;

  assign ctrl_wr   = (wraddr == CTRL_ADDR) && (wea == 4'hf);
  assign arm       = ctrl_wr && wdata[CTRL_ARM];
  assign stop      = ctrl_wr && wdata[CTRL_STOP];
  assign abort     = ctrl_wr && wdata[CTRL_ABORT];
  assign ack       = ctrl_wr && wdata[CTRL_ACK];
  assign rcev      = (hw_state == HW_RCEV);
  assign smp_we    = (state == ST_CAPTURE) && smp_valid;
  assign last_slot = &wr_ptr;
  assign busy      = (state == ST_CAPTURE);
  assign unused_wdata = ^{wdata[31:CTRL_CHSEL_LSB+CTRL_CHSEL_W],
                          wdata[CTRL_CHSEL_LSB-1:CTRL_MODE+1]};

  // Capture FSM; abort beats stop beats arm, and a strobe in a leaving cycle is still stored.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state    <= ST_IDLE;
      wr_ptr   <= '0;
      count    <= '0;
      wrapped  <= 1'b0;
      mode     <= 1'b0;
      ch_sel   <= '0;
      irq_done <= 1'b0;
    end else begin
      irq_done <= 1'b0;
      if (ctrl_wr) ch_sel <= wdata[CTRL_CHSEL_LSB +: CTRL_CHSEL_W];
      if (smp_we) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= sat_inc(count);
        if (mode && last_slot) wrapped <= 1'b1;
      end
      case (state)
        ST_CAPTURE: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (stop) begin
            state    <= ST_DONE;
            irq_done <= 1'b1;
          end else if (!rcev) begin
            state <= ST_IDLE;
          end else if (smp_we && !mode && last_slot) begin
            state    <= ST_DONE;
            irq_done <= 1'b1;
          end
        end
        default: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (arm && !stop && rcev) begin
            state   <= ST_CAPTURE;
            wr_ptr  <= '0;
            count   <= '0;
            wrapped <= 1'b0;
            mode    <= wdata[CTRL_MODE];
          end else if (ack) begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  logic [BUS_AW-1:0]     offset;
  logic                  buf_hit;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [SMP_W-1:0]      ram_q;

  assign offset  = rdaddr - BASE_ADDR;
  assign buf_hit = (rdaddr >= BASE_ADDR) && (32'(offset) < 32'(DEPTH));
  assign rd_idx  = wrapped ? wr_ptr + offset[DEPTH_LOG2-1:0] : offset[DEPTH_LOG2-1:0];

  fm_capture_ram #(
    .WIDTH  (SMP_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .we    (smp_we),
    .waddr (wr_ptr),
    .wdata (smp_data),
    .raddr (rd_idx),
    .rdata (ram_q)
  );

  // Read stage p1: decode registered alongside the RAM read, muxed out next cycle.
  rd_kind_t    rd_kind_p1;
  logic [3:0]  rd_ch_p1;
  logic [31:0] stat_p1;
  logic [31:0] rd_hold;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      rd_kind_p1 <= RD_NONE;
      rd_hold    <= '0;
    end else begin
      rd_hold <= rdata;
      if (rdaddr == STAT_ADDR)  rd_kind_p1 <= RD_STAT;
      else if (buf_hit)         rd_kind_p1 <= (state == ST_CAPTURE) ? RD_ZERO : RD_BUF;
      else                      rd_kind_p1 <= RD_NONE;
    end
  end

  always_ff @(posedge clk) begin
    rd_ch_p1 <= ch_sel;
    stat_p1  <= pack_status(wrapped, mode, state, count);
  end

  logic [DATA_W-1:0] ch_word;

  always_comb begin
    ch_word = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_ch_p1 == 4'(c)) ch_word = ram_q[c*DATA_W +: DATA_W];
    end
    case (rd_kind_p1)
      RD_STAT: rdata = stat_p1;
      RD_BUF:  rdata = 32'(ch_word);
      RD_ZERO: rdata = '0;
      default: rdata = rd_hold;
    endcase
  end

endmodule
